// File: rtl/uart_rx_core.sv
// 8N1 UART receiver: synchronizes the RX pin, finds the start edge and samples each bit at mid-bit.
// Good bytes are signalled with r_done_o; a low stop bit is signalled with frame_err_o.
module uart_rx_core #(
    parameter int SYNC_STAGES  = 2,
    parameter int MIN_BAUD_DIV = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        rx_en_i,
    input  logic [15:0] baud_div_i,
    input  logic        rx_pin_i,
    output logic [7:0]  rx_data_o,
    output logic        r_done_o,
    output logic        frame_err_o,
    output logic        busy_o
);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t                 state;
    logic [SYNC_STAGES-1:0] sync;
    logic                   rx_s;
    logic                   rx_q;
    logic [15:0]            bd_lat;
    logic [15:0]            cnt;
    logic [2:0]             bit_idx;
    logic [7:0]             shreg;
    logic                   tick;
    logic                   bd_ok;
    logic                   start_det;

    assign rx_s      = sync[SYNC_STAGES-1];
    assign tick      = (cnt == 16'd0);
    assign bd_ok     = (baud_div_i >= 16'(MIN_BAUD_DIV));
    assign start_det = rx_en_i && bd_ok && rx_q && !rx_s;

    // Synchronizer and edge-detect flops reset to the idle (high) line level.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync <= '1;
            rx_q <= 1'b1;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], rx_pin_i};
            rx_q <= rx_s;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state       <= IDLE;
            bd_lat      <= 16'd0;
            cnt         <= 16'd0;
            bit_idx     <= 3'd0;
            shreg       <= 8'd0;
            rx_data_o   <= 8'd0;
            r_done_o    <= 1'b0;
            frame_err_o <= 1'b0;
            busy_o      <= 1'b0;
        end else begin
            r_done_o    <= 1'b0;
            frame_err_o <= 1'b0;
            if (!rx_en_i) begin
                state  <= IDLE;
                busy_o <= 1'b0;
                cnt    <= 16'd0;
            end else begin
                case (state)
                    IDLE: begin
                        // First tick lands half a bit in, i.e. mid start bit.
                        if (start_det) begin
                            bd_lat <= baud_div_i;
                            cnt    <= (baud_div_i >> 1) - 16'd1;
                            state  <= START;
                            busy_o <= 1'b1;
                        end
                    end
                    START: begin
                        if (!tick) begin
                            cnt <= cnt - 16'd1;
                        end else if (rx_s) begin
                            state  <= IDLE;
                            busy_o <= 1'b0;
                        end else begin
                            cnt     <= bd_lat - 16'd1;
                            bit_idx <= 3'd0;
                            state   <= DATA;
                        end
                    end
                    DATA: begin
                        if (!tick) begin
                            cnt <= cnt - 16'd1;
                        end else begin
                            shreg[bit_idx] <= rx_s;
                            cnt            <= bd_lat - 16'd1;
                            if (bit_idx == 3'd7) begin
                                state <= STOP;
                            end else begin
                                bit_idx <= bit_idx + 3'd1;
                            end
                        end
                    end
                    STOP: begin
                        // Leaving at mid stop bit lets a back-to-back start edge be caught.
                        if (!tick) begin
                            cnt <= cnt - 16'd1;
                        end else begin
                            state  <= IDLE;
                            busy_o <= 1'b0;
                            if (rx_s) begin
                                rx_data_o <= shreg;
                                r_done_o  <= 1'b1;
                            end else begin
                                frame_err_o <= 1'b1;
                            end
                        end
                    end
                    default: begin
                        state  <= IDLE;
                        busy_o <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_core.sv
// Directed bench for uart_rx_core: a frame-level scoreboard predicts every pulse and the
// held rx_data_o value, checked on each falling clock edge, plus literal spot checks.
module tb_uart_rx_core;

    typedef struct {
        logic       err;
        logic [7:0] val;
    } ev_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rx_en = 1'b0;
    logic [15:0] baud_div = 16'd16;
    logic        rx_pin = 1'b1;
    logic [7:0]  rx_data;
    logic        r_done;
    logic        frame_err;
    logic        busy;

    int   total = 0;
    int   bad = 0;
    int   n_done = 0;
    int   n_err = 0;
    int   busy_cycles = 0;
    logic [7:0] model_data = 8'd0;
    logic prev_pulse = 1'b0;
    ev_t  exp_q[$];
    ev_t  ev;

    uart_rx_core #(.SYNC_STAGES(2), .MIN_BAUD_DIV(4)) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .rx_en_i    (rx_en),
        .baud_div_i (baud_div),
        .rx_pin_i   (rx_pin),
        .rx_data_o  (rx_data),
        .r_done_o   (r_done),
        .frame_err_o(frame_err),
        .busy_o     (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard: every pulse must match the oldest expected frame outcome.
    always @(negedge clk) begin
        if (rst) begin
            check("reset_outputs", {rx_data, r_done, frame_err, busy}, 32'd0);
            model_data = 8'd0;
            prev_pulse = 1'b0;
        end else begin
            if (busy) busy_cycles++;
            if (r_done && frame_err) check("pulse_exclusive", 32'd1, 32'd0);
            if ((r_done || frame_err) && prev_pulse) check("pulse_consecutive", 32'd1, 32'd0);
            if (r_done || frame_err) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_pulse", {r_done, frame_err}, 32'd0);
                end else begin
                    ev = exp_q.pop_front();
                    check("pulse_kind", {r_done, frame_err}, {ev.err ? 2'b01 : 2'b10});
                    if (!ev.err) begin
                        model_data = ev.val;
                        n_done++;
                    end else begin
                        n_err++;
                    end
                end
            end
            check("rx_data_hold", rx_data, model_data);
            prev_pulse = r_done || frame_err;
        end
    end

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // mode: 0 normal, 1 drop rx_en in bit 4, 2 reset in bit 4, 3 change baud_div mid-frame
    task automatic applyStimulus(input logic [7:0] byte_val, input logic stop, input int per,
                                 input int mode, input bit want);
        logic [9:0] bits;
        bits = {stop, byte_val, 1'b0};
        if (want) exp_q.push_back('{err: ~stop, val: byte_val});
        for (int b = 0; b < 10; b++) begin
            rx_pin = bits[b];
            if (b == 5 && (mode == 1 || mode == 2)) begin
                wait_cycles(per / 2);
                if (mode == 1) rx_en = 1'b0;
                else rst = 1'b1;
                rx_pin = 1'b1;
                @(posedge clk);
                @(negedge clk);
                check("abort_busy", busy, 32'd0);
                wait_cycles(per * 5);
                rx_en = 1'b1;
                rst   = 1'b0;
                wait_cycles(per);
                return;
            end
            if (b == 3 && mode == 3) baud_div = 16'd3;
            wait_cycles(per);
        end
        if (mode == 3) baud_div = 16'(per);
    endtask

    task automatic checkOutput(input string name);
        int guard;
        guard = 0;
        while (exp_q.size() != 0 && guard < 64) begin
            wait_cycles(1);
            guard++;
        end
        check(name, exp_q.size(), 32'd0);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int d0;
        int e0;
        wait_cycles(4);
        check("reset_busy", busy, 32'd0);
        rst = 1'b0;
        wait_cycles(3);
        rx_en = 1'b1;
        wait_cycles(5);

        applyStimulus(8'hA5, 1'b1, 16, 0, 1'b1);
        checkOutput("t1_drain");
        check("t1_data", rx_data, 32'hA5);
        check("t1_done", n_done, 32'd1);
        check("t1_err", n_err, 32'd0);

        applyStimulus(8'h3C, 1'b0, 16, 0, 1'b1);
        rx_pin = 1'b1;
        checkOutput("t2_drain");
        wait_cycles(8);
        check("t2_data", rx_data, 32'hA5);
        check("t2_err", n_err, 32'd1);
        check("t2_done", n_done, 32'd1);

        busy_cycles = 0;
        rx_pin = 1'b0;
        wait_cycles(3);
        rx_pin = 1'b1;
        wait_cycles(24);
        check("t3_busy_seen", busy_cycles > 0, 32'd1);
        check("t3_busy_len", busy_cycles <= 8, 32'd1);
        check("t3_busy_now", busy, 32'd0);
        check("t3_counts", n_done + n_err, 32'd2);

        baud_div = 16'd10;
        applyStimulus(8'h00, 1'b1, 10, 0, 1'b1);
        applyStimulus(8'hFF, 1'b1, 10, 0, 1'b1);
        checkOutput("t4_drain");
        check("t4_data", rx_data, 32'hFF);
        check("t4_done", n_done, 32'd3);

        baud_div = 16'd16;
        wait_cycles(10);
        applyStimulus(8'hE7, 1'b1, 16, 1, 1'b0);
        applyStimulus(8'h5A, 1'b1, 16, 3, 1'b1);
        checkOutput("t5_drain");
        check("t5_data", rx_data, 32'h5A);
        check("t5_done", n_done, 32'd4);

        applyStimulus(8'h77, 1'b1, 16, 2, 1'b0);
        check("t6_rst_data", rx_data, 32'h00);
        applyStimulus(8'h81, 1'b1, 16, 0, 1'b1);
        checkOutput("t6_drain");
        check("t6_data", rx_data, 32'h81);

        baud_div = 16'd4;
        wait_cycles(4);
        applyStimulus(8'hC3, 1'b1, 4, 0, 1'b1);
        checkOutput("t6_min_drain");
        check("t6_min_data", rx_data, 32'hC3);

        baud_div = 16'd3;
        busy_cycles = 0;
        d0 = n_done;
        e0 = n_err;
        wait_cycles(4);
        applyStimulus(8'h18, 1'b1, 3, 0, 1'b0);
        wait_cycles(20);
        check("t6_bd3_busy", busy_cycles, 32'd0);
        check("t6_bd3_pulses", (n_done - d0) + (n_err - e0), 32'd0);
        check("t6_bd3_data", rx_data, 32'hC3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
